phy_ber_test_ctrl: RTL and testbench

PHY_BER_TEST_CTRL -- requirements
Module: phy_ber_test_ctrl

---
 rtl/phy_ber_pkg.sv | 19 +
 rtl/ber_sat_accum.sv | 36 +++
 rtl/phy_ber_test_ctrl.sv | 161 ++++++++++++++++
 tb/tb_phy_ber_test_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/phy_ber_pkg.sv
// Shared types for the PHY PRBS31 bit-error-rate test controller:
// controller state encoding and the status codes reported with done.
package phy_ber_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StPhyRst,
    StWaitLock,
    StSettle,
    StMeasure,
    StDone
  } state_e;

  localparam logic [1:0] StatusPass        = 2'd0;
  localparam logic [1:0] StatusLockTimeout = 2'd1;
  localparam logic [1:0] StatusLockLost    = 2'd2;
  localparam logic [1:0] StatusBer         = 2'd3;

endpackage

// File: rtl/ber_sat_accum.sv
// 32-bit saturating accumulator with synchronous clear and add-enable.
// o_sum_next exposes the value that will be registered on the next edge.
module ber_sat_accum (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_clr,
  input  logic        i_en,
  input  logic [31:0] i_add,
  output logic [31:0] o_sum,
  output logic [31:0] o_sum_next
);

  logic [31:0] r_sum;
  logic [32:0] w_raw;

  always_comb begin
    w_raw      = {1'b0, r_sum} + {1'b0, i_add};
    o_sum_next = r_sum;
    if (i_clr) begin
      o_sum_next = '0;
    end else if (i_en) begin
      o_sum_next = w_raw[32] ? 32'hFFFF_FFFF : w_raw[31:0];
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sum <= '0;
    end else begin
      r_sum <= o_sum_next;
    end
  end

  assign o_sum = r_sum;

endmodule

// File: rtl/phy_ber_test_ctrl.sv
// Sequences a PHY through reset, block lock and a PRBS31 measurement window,
// accumulating reported bit errors and classifying the run outcome.
module phy_ber_test_ctrl
  import phy_ber_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 4096,
  parameter int unsigned SETTLE_CYCLES = 64,
  parameter int unsigned ERR_THRESH    = 0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic        i_abort,
  input  logic [31:0] i_cfg_window,
  input  logic        i_rx_block_lock,
  input  logic        i_rx_high_ber,
  input  logic [6:0]  i_rx_error_count,
  output logic        o_phy_rst,
  output logic        o_cfg_prbs31_enable,
  output logic        o_busy,
  output logic        o_done,
  output logic [1:0]  o_status,
  output logic [31:0] o_err_total,
  output logic [31:0] o_lock_cycles
);

  state_e      r_state, w_state_next;
  logic [31:0] r_cnt, w_cnt_next;
  logic [31:0] r_window;
  logic [1:0]  r_status, w_status_next;
  logic        w_clr, w_err_en, w_lock_en;
  logic [31:0] w_err_sum, w_err_next, w_lock_sum, w_lock_next;

  assign w_clr     = (r_state == StIdle) && i_start;
  assign w_err_en  = (r_state == StMeasure) && i_rx_block_lock && !i_abort;
  assign w_lock_en = (r_state == StWaitLock) && !i_rx_block_lock && !i_abort;

  ber_sat_accum u_err_accum (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_clr      (w_clr),
    .i_en       (w_err_en),
    .i_add      ({25'd0, i_rx_error_count}),
    .o_sum      (w_err_sum),
    .o_sum_next (w_err_next)
  );

  ber_sat_accum u_lock_accum (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_clr      (w_clr),
    .i_en       (w_lock_en),
    .i_add      (32'd1),
    .o_sum      (w_lock_sum),
    .o_sum_next (w_lock_next)
  );

  // Priority inside a state: abort, then lock lost, then high BER, then count expiry.
  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    w_status_next = r_status;
    if (r_state != StIdle && i_abort) begin
      w_state_next = StIdle;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            w_state_next  = StPhyRst;
            w_cnt_next    = 32'(RST_CYCLES - 1);
            w_status_next = StatusPass;
          end
        end
        StPhyRst: begin
          if (r_cnt == '0) begin
            w_state_next = StWaitLock;
            w_cnt_next   = 32'(LOCK_TIMEOUT - 1);
          end else begin
            w_cnt_next = r_cnt - 32'd1;
          end
        end
        StWaitLock: begin
          if (i_rx_block_lock) begin
            w_state_next = StSettle;
            w_cnt_next   = 32'(SETTLE_CYCLES - 1);
          end else if (r_cnt == '0) begin
            w_state_next  = StDone;
            w_status_next = StatusLockTimeout;
          end else begin
            w_cnt_next = r_cnt - 32'd1;
          end
        end
        StSettle: begin
          if (!i_rx_block_lock) begin
            w_state_next  = StDone;
            w_status_next = StatusLockLost;
          end else if (r_cnt == '0) begin
            if (r_window == '0) begin
              w_state_next  = StDone;
              w_status_next = StatusPass;
            end else begin
              w_state_next = StMeasure;
              w_cnt_next   = r_window - 32'd1;
            end
          end else begin
            w_cnt_next = r_cnt - 32'd1;
          end
        end
        StMeasure: begin
          if (!i_rx_block_lock) begin
            w_state_next  = StDone;
            w_status_next = StatusLockLost;
          end else if (i_rx_high_ber) begin
            w_state_next  = StDone;
            w_status_next = StatusBer;
          end else if (r_cnt == '0) begin
            // Judge on the post-accumulation total so the last cycle's errors count.
            w_state_next  = StDone;
            w_status_next = (w_err_next <= 32'(ERR_THRESH)) ? StatusPass : StatusBer;
          end else begin
            w_cnt_next = r_cnt - 32'd1;
          end
        end
        StDone: begin
          w_state_next = StIdle;
        end
        default: begin
          w_state_next = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state  <= StIdle;
      r_cnt    <= '0;
      r_window <= '0;
      r_status <= StatusPass;
    end else begin
      r_state  <= w_state_next;
      r_cnt    <= w_cnt_next;
      r_status <= w_status_next;
      if (w_clr) begin
        r_window <= i_cfg_window;
      end
    end
  end

  always_comb begin
    o_phy_rst           = (r_state == StPhyRst);
    o_cfg_prbs31_enable = (r_state == StSettle) || (r_state == StMeasure);
    o_busy              = (r_state != StIdle);
    o_done              = (r_state == StDone);
    o_status            = r_status;
    o_err_total         = w_err_sum;
    o_lock_cycles       = w_lock_sum;
  end

endmodule

// File: tb/tb_phy_ber_test_ctrl.sv
// Self-checking bench: runs are described as a timeline (lock delay, window,
// lock-loss / high-BER / abort points) and every cycle's outputs are predicted from it.
module tb_phy_ber_test_ctrl;

  localparam int RST = 16;
  localparam int TO  = 4096;
  localparam int S   = 64;
  localparam int TH  = 0;

  logic        clk = 1'b0;
  logic        rst_n, start, abort, lock, high_ber;
  logic [31:0] window;
  logic [6:0]  err_cnt;
  logic        phy_rst, prbs_en, busy, done;
  logic [1:0]  status;
  logic [31:0] err_total, lock_cycles;

  logic        a_rst_n, a_clr, a_en;
  logic [31:0] a_add, a_sum, a_sum_next;

  int n_checks = 0;
  int n_errors = 0;

  // Scenario description and derived timeline (cycle 1 = first cycle after start edge)
  int sc_l, sc_w, sc_lost, sc_ber, sc_ab, sc_bnoise;
  bit sc_ab_rst;
  int cw, s0, m0, t_end, exp_stat;
  longint exp_err, exp_lock;
  int unsigned errv [0:8191];

  always #5 clk = ~clk;

  phy_ber_test_ctrl u_dut (
    .i_clk               (clk),
    .i_rst_n             (rst_n),
    .i_start             (start),
    .i_abort             (abort),
    .i_cfg_window        (window),
    .i_rx_block_lock     (lock),
    .i_rx_high_ber       (high_ber),
    .i_rx_error_count    (err_cnt),
    .o_phy_rst           (phy_rst),
    .o_cfg_prbs31_enable (prbs_en),
    .o_busy              (busy),
    .o_done              (done),
    .o_status            (status),
    .o_err_total         (err_total),
    .o_lock_cycles       (lock_cycles)
  );

  ber_sat_accum u_acc (
    .i_clk      (clk),
    .i_rst_n    (a_rst_n),
    .i_clr      (a_clr),
    .i_en       (a_en),
    .i_add      (a_add),
    .o_sum      (a_sum),
    .o_sum_next (a_sum_next)
  );

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // 0 idle, 1 phy reset, 2 wait lock, 3 settle, 4 measure, 5 done
  function automatic int phase(input int c);
    if (sc_ab > 0 && c > sc_ab) return 0;
    if (c < 1) return 0;
    if (c <= RST) return 1;
    if (c < t_end) begin
      if (c < s0) return 2;
      if (c < m0) return 3;
      return 4;
    end
    if (c == t_end) return 5;
    return 0;
  endfunction

  function automatic bit lock_in(input int c);
    if (sc_l < 0) return 1'b0;
    if (c < cw + sc_l) return 1'b0;
    if (sc_lost >= 0 && c >= s0 + sc_lost) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit ber_in(input int c);
    if (sc_ber >= 0 && c == m0 + sc_ber) return 1'b1;
    return (c == sc_bnoise);
  endfunction

  // ab: abort/reset cycle, -1 none, -2 pick at random; rnd: randomize errors and noise
  task automatic run(input int l, input int w, input int lost, input int ber, input int ab,
                     input bit ab_rst, input bit rnd);
    int last, ph;
    bit clean;
    sc_l = l; sc_w = w; sc_lost = lost; sc_ber = ber; sc_ab = -1; sc_ab_rst = ab_rst;
    sc_bnoise = -1;
    cw = RST + 1;
    exp_stat = -1;
    if (l < 0) begin
      t_end = cw + TO; exp_stat = 1; s0 = t_end + 100; m0 = s0;
    end else begin
      s0 = cw + l + 1;
      m0 = s0 + S;
      if (lost >= 0 && lost < S) begin
        t_end = s0 + lost + 1; exp_stat = 2;
      end else if (w == 0) begin
        t_end = m0; exp_stat = 0;
      end else begin
        t_end = 0;
        for (int i = 0; i < w; i++) begin
          if (lost >= 0 && s0 + lost == m0 + i) begin
            t_end = m0 + i + 1; exp_stat = 2; break;
          end
          if (ber == i) begin
            t_end = m0 + i + 1; exp_stat = 3; break;
          end
        end
        if (t_end == 0) t_end = m0 + w;
      end
    end
    if (ab == -2) sc_ab = ($urandom_range(0, 9) < 3) ? int'($urandom_range(1, t_end - 1)) : -1;
    else sc_ab = ab;
    if (rnd) begin
      clean = $urandom_range(0, 1);
      for (int c = 0; c < 8192; c++)
        errv[c] = (!clean && $urandom_range(0, 7) == 0) ? $urandom_range(1, 127) : 0;
      if (l >= 0) sc_bnoise = s0 + int'($urandom_range(0, S - 1));
    end
    exp_err = 0; exp_lock = 0;
    for (int c = 1; c <= t_end; c++) begin
      if (sc_ab > 0 && c >= sc_ab) break;
      ph = phase(c);
      if (ph == 4 && lock_in(c)) begin
        exp_err += errv[c];
        if (exp_err > 64'hFFFF_FFFF) exp_err = 64'hFFFF_FFFF;
      end
      if (ph == 2 && !lock_in(c)) exp_lock++;
    end
    if (exp_stat < 0) exp_stat = (exp_err <= TH) ? 0 : 3;
    if (sc_ab > 0) begin
      exp_stat = 0;
      if (ab_rst) begin exp_err = 0; exp_lock = 0; end
    end

    @(negedge clk);
    start = 1'b1; window = 32'(w);
    @(posedge clk);
    last = ((sc_ab > 0) ? sc_ab + 1 : t_end) + 2;
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      ph = phase(c);
      check_val("outs", {phy_rst, prbs_en, busy, done},
                {ph == 1, ph == 3 || ph == 4, ph != 0, ph == 5});
      if ((sc_ab <= 0 && (c == t_end || c == last)) || (sc_ab > 0 && c >= sc_ab + 1)) begin
        check_val("status", status, 64'(exp_stat));
        check_val("err_total", err_total, 64'(exp_err));
        check_val("lock_cycles", lock_cycles, 64'(exp_lock));
      end
      lock     = lock_in(c);
      high_ber = ber_in(c);
      err_cnt  = 7'(errv[c]);
      start    = (ph != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      window   = $urandom;
      abort    = (c == sc_ab) && !ab_rst;
      rst_n    = !((c == sc_ab) && ab_rst);
      @(posedge clk);
    end
    @(negedge clk);
    start = 1'b0; abort = 1'b0; rst_n = 1'b1; lock = 1'b0; high_ber = 1'b0; err_cnt = '0;
  endtask

  initial begin
    longint acc_exp;
    logic [31:0] adds [0:5];
    int l, w, lost, ber;

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; lock = 1'b0; high_ber = 1'b0;
    window = '0; err_cnt = '0;
    a_rst_n = 1'b0; a_clr = 1'b0; a_en = 1'b0; a_add = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_outs", {phy_rst, prbs_en, busy, done}, 4'b0000);
    check_val("rst_status", status, 0);
    check_val("rst_err", err_total, 0);
    check_val("rst_lock", lock_cycles, 0);
    rst_n = 1'b1; a_rst_n = 1'b1;

    for (int c = 0; c < 8192; c++) errv[c] = 0;
    run(10, 500, -1, -1, -1, 1'b0, 1'b0);
    check_val("pass_lock10", lock_cycles, 10);
    run(-1, 50, -1, -1, -1, 1'b0, 1'b0);
    check_val("timeout_status", status, 1);

    // Lock at +5: SETTLE from cycle 23, MEASURE from cycle 87
    errv[30] = 7;
    errv[89] = 3; errv[97] = 3; errv[107] = 3; errv[137] = 3; errv[186] = 3;
    run(5, 100, -1, -1, -1, 1'b0, 1'b0);
    check_val("err15", err_total, 15);
    check_val("err15_status", status, 3);
    for (int c = 0; c < 8192; c++) errv[c] = 0;
    run(3, 100, S + 40, 40, -1, 1'b0, 1'b0);
    check_val("lost_vs_ber", status, 2);

    for (int c = 0; c < 8192; c++) errv[c] = 127;
    run(2, 8, -1, -1, -1, 1'b0, 1'b0);
    check_val("w8_err", err_total, 1016);
    run(2, 0, -1, -1, -1, 1'b0, 1'b0);
    check_val("w0_status", status, 0);
    for (int c = 0; c < 8192; c++) errv[c] = 0;
    run(-1, 10, -1, -1, RST + 1 + 20, 1'b0, 1'b0);
    check_val("abort_lock", lock_cycles, 20);
    errv[100] = 9;
    run(4, 200, -1, -1, 86 + 30, 1'b1, 1'b0);

    for (int r = 0; r < 25; r++) begin
      if ($urandom_range(0, 11) == 0) l = -1;
      else l = $urandom_range(0, 40);
      w = $urandom_range(0, 150);
      lost = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, S + w - 1)) : -1;
      ber = (w > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, w - 1)) : -1;
      run(l, w, lost, ber, -2, 1'($urandom_range(0, 1)), 1'b1);
    end

    // Saturation of the accumulator near full scale
    adds[0] = 32'hFFFF_FF00; adds[1] = 127; adds[2] = 127;
    adds[3] = 127; adds[4] = 127; adds[5] = 32'hFFFF_FFFF;
    @(negedge clk);
    a_clr = 1'b1;
    @(negedge clk);
    a_clr = 1'b0;
    check_val("acc_clr", a_sum, 0);
    acc_exp = 0;
    for (int i = 0; i < 6; i++) begin
      a_en = 1'b1; a_add = adds[i];
      acc_exp = acc_exp + adds[i];
      if (acc_exp > 64'hFFFF_FFFF) acc_exp = 64'hFFFF_FFFF;
      @(negedge clk);
      check_val("acc_sat", a_sum, 64'(acc_exp));
    end
    a_en = 1'b0; a_add = 5;
    @(negedge clk);
    check_val("acc_hold", a_sum, 64'hFFFF_FFFF);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not finish, got hang expected finish");
    $fatal(1);
  end

endmodule
